// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU-side ports, the arbiter and the memory port.
//
// Handshake: a CPU port requests by driving a nonzero mask (imem: rmask,
// dmem: rmask or wmask) and holds address/masks/data stable until its
// *_resp pulse; resp is a single-cycle pulse that completes the request,
// and the port may present a new request in the following cycle. The
// memory side sees one request at a time on mem_* (nonzero mask) and
// completes it with a one-cycle mem_resp, carrying read data on mem_rdata.
interface mem_arbiter_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  // Arbiter view.
  modport slave (
    input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask,
           dmem_wdata, mem_rdata, mem_resp,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
           mem_addr, mem_rmask, mem_wmask, mem_wdata
  );

  // CPU and memory view.
  modport master (
    output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask,
           dmem_wdata, mem_rdata, mem_resp,
    input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
           mem_addr, mem_rmask, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one round-robin memory arbiter (fetch port vs load/store port)
// with one outstanding transaction and a sticky no-response watchdog.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  mem_arbiter_if.slave bus,
  output logic       timeout_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  // The busy counter value during the last busy cycle before the error.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        last_grant_d;       // 0: fetch won last, 1: data won last
  logic        imem_req, dmem_req;
  logic        grant_i, grant_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  rmask_q, wmask_q;
  logic [15:0] busy_cnt;
  logic        err_q;

  assign imem_req = |bus.imem_rmask;
  assign dmem_req = |bus.dmem_rmask || |bus.dmem_wmask;

  // Next state and grant decision; ties go to the port not granted last.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (imem_req && dmem_req) begin
          grant_d = ~last_grant_d;
          grant_i = last_grant_d;
        end else begin
          grant_i = imem_req;
          grant_d = dmem_req;
        end
        if (grant_i)      state_next = I_BUSY;
        else if (grant_d) state_next = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (bus.mem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and last-grant memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_i)      last_grant_d <= 1'b0;
      else if (grant_d) last_grant_d <= 1'b1;
    end
  end

  // Memory-side request registers: latched on grant, cleared on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else if (grant_i) begin
      addr_q  <= bus.imem_addr;
      rmask_q <= bus.imem_rmask;
      wmask_q <= '0;
      wdata_q <= '0;
    end else if (grant_d) begin
      addr_q  <= bus.dmem_addr;
      rmask_q <= bus.dmem_rmask;
      wmask_q <= bus.dmem_wmask;
      wdata_q <= bus.dmem_wdata;
    end else if (state != IDLE && bus.mem_resp) begin
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end
  end

  // Watchdog: counts busy cycles of the current transaction; the error
  // sticks until reset and never aborts the transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        busy_cnt <= '0;
      end else if (state != IDLE && busy_cnt != 16'hFFFF) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
      if (state != IDLE && !bus.mem_resp && busy_cnt == LAST_CNT) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_rmask  = rmask_q;
  assign bus.mem_wmask  = wmask_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.imem_resp  = (state == I_BUSY) && bus.mem_resp;
  assign bus.dmem_resp  = (state == D_BUSY) && bus.mem_resp;
  assign bus.imem_rdata = (state == I_BUSY) ? bus.mem_rdata : 32'h0;
  assign bus.dmem_rdata = (state == D_BUSY) ? bus.mem_rdata : 32'h0;
  assign timeout_err    = err_q;
  assign dbg_state      = state;

endmodule
